// File: rtl/pio_irq_service_ctrl.sv
// pio_irq_service_ctrl: Avalon-MM master that programs and services a 2-bit edge-capture PIO (optional poll tick under PIO_SVC_POLL_EN)
module pio_irq_service_ctrl #(
  parameter int WIDTH = 2,
  parameter int MAX_BURST = 255
`ifdef PIO_SVC_POLL_EN
  , parameter int POLL_PERIOD = 1024
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] mask_cfg,
  output logic [1:0]       pio_address,
  output logic             pio_chipselect,
  output logic             pio_write_n,
  output logic [31:0]      pio_writedata,
  input  logic [31:0]      pio_readdata,
  input  logic             pio_irq,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [WIDTH-1:0] evt_edges,
  output logic [WIDTH-1:0] evt_level,
  output logic [7:0]       evt_count,
  output logic             busy
);
  typedef enum logic [2:0] {INIT, IDLE, RD_CAP, CLR_CAP, RD_DAT, LATCH, PUSH} state_t;
  state_t state;
  logic [WIDTH-1:0] mask_shadow;
  logic [WIDTH-1:0] cap;
  logic tick;
  logic unused_rd;
  assign unused_rd = ^pio_readdata[31:WIDTH];
  assign busy = state != IDLE;
`ifdef PIO_SVC_POLL_EN
  logic [31:0] poll_cnt;
  assign tick = poll_cnt == 32'd0;
  // free-running poll divider, reloads when it reaches zero
  always_ff @(posedge clk) begin
    if (reset) poll_cnt <= 32'(POLL_PERIOD - 1);
    else poll_cnt <= tick ? 32'(POLL_PERIOD - 1) : poll_cnt - 32'd1;
  end
`else
  assign tick = 1'b0;
`endif
  // service FSM; bus outputs are registered for the state being entered so each access lines up with its state
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= INIT;
      pio_chipselect <= 1'b0;
      pio_write_n    <= 1'b1;
      pio_address    <= 2'd0;
      pio_writedata  <= 32'd0;
      evt_valid      <= 1'b0;
      evt_edges      <= '0;
      evt_level      <= '0;
      evt_count      <= 8'd0;
      mask_shadow    <= '0;
      cap            <= '0;
    end else begin
      pio_chipselect <= 1'b0;
      pio_write_n    <= 1'b1;
      pio_address    <= 2'd0;
      pio_writedata  <= 32'd0;
      case (state)
        INIT: begin
          pio_chipselect <= 1'b1;
          pio_write_n    <= 1'b0;
          pio_address    <= 2'd2;
          pio_writedata  <= 32'(mask_cfg);
          mask_shadow    <= mask_cfg;
          state          <= IDLE;
        end
        IDLE: begin
          if (mask_cfg != mask_shadow) state <= INIT;
          else if (pio_irq || tick) begin
            pio_chipselect <= 1'b1;
            pio_address    <= 2'd3;
            state          <= RD_CAP;
          end
        end
        RD_CAP: begin
          pio_chipselect <= 1'b1;
          pio_write_n    <= 1'b0;
          pio_address    <= 2'd3;
          pio_writedata  <= '1;
          state          <= CLR_CAP;
        end
        CLR_CAP: begin
          cap            <= pio_readdata[WIDTH-1:0] & mask_shadow;
          pio_chipselect <= 1'b1;
          pio_address    <= 2'd0;
          state          <= RD_DAT;
        end
        RD_DAT: state <= LATCH;
        LATCH: begin
          evt_level <= pio_readdata[WIDTH-1:0];
          if (cap == '0) state <= IDLE;
          else begin
            evt_edges <= cap;
            evt_valid <= 1'b1;
            state     <= PUSH;
          end
        end
        PUSH: begin
          if (evt_ready) begin
            evt_valid <= 1'b0;
            evt_count <= (evt_count == 8'(MAX_BURST)) ? evt_count : evt_count + 8'd1;
            state     <= IDLE;
          end
        end
        default: state <= INIT;
      endcase
    end
  end
endmodule
